// File: rtl/player_ctrl_multi_if.sv
// rtl/player_ctrl_multi_if.sv - command, codec and memreader signal bundle for player_ctrl_multi
//
// Purpose: groups every non-clock/reset signal of the player control unit.
//   master modport: the player controller (consumes keys/codec status, drives address stream)
//   slave modport : the surrounding board (keys/remote decoder, audio_interface, memreader)
// Signals:
//   init_finish, sample_req, cmd_* , loop_mode  -> controller
//   mem_addr, mem_rd, song_idx, speed_lvl, RW, PAUSE, song_end  <- controller
interface player_ctrl_multi_if #(
  parameter int NUM_SONGS  = 4,
  parameter int ADDR_W     = 23,
  parameter int SPEED_LVLS = 4
) ();
  localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int SPD_W  = $clog2(SPEED_LVLS);

  logic              init_finish;
  logic              sample_req;
  logic              cmd_play_pause;
  logic              cmd_restart;
  logic              cmd_next;
  logic              cmd_prev;
  logic              cmd_fast;
  logic              cmd_slow;
  logic              loop_mode;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic [SONG_W-1:0] song_idx;
  logic [SPD_W-1:0]  speed_lvl;
  logic              RW;
  logic              PAUSE;
  logic              song_end;

  modport master (
    input  init_finish, sample_req, cmd_play_pause, cmd_restart, cmd_next,
           cmd_prev, cmd_fast, cmd_slow, loop_mode,
    output mem_addr, mem_rd, song_idx, speed_lvl, RW, PAUSE, song_end
  );

  modport slave (
    output init_finish, sample_req, cmd_play_pause, cmd_restart, cmd_next,
           cmd_prev, cmd_fast, cmd_slow, loop_mode,
    input  mem_addr, mem_rd, song_idx, speed_lvl, RW, PAUSE, song_end
  );
endinterface

// File: rtl/player_ctrl_multi.sv
// rtl/player_ctrl_multi.sv - multi-song play/pause controller with speed and navigation
//
// Purpose: player state machine (IDLE/INIT/PAUSE/PLAY) plus a playlist of NUM_SONGS
//   fixed-size flash regions; produces the sample byte-address stream for memreader.
// Ports:
//   CLOCK - system clock
//   Reset - asynchronous active-high reset
//   bus   - player_ctrl_multi_if.master (commands/codec status in, address stream out)
module player_ctrl_multi #(
  parameter int NUM_SONGS    = 4,
  parameter int ADDR_W       = 23,
  parameter int SONG_BYTES   = 2097152,
  parameter int SAMPLE_BYTES = 2,
  parameter int SPEED_LVLS   = 4
) (
  input  logic                CLOCK,
  input  logic                Reset,
  player_ctrl_multi_if.master bus
);
  localparam int SONG_W = (NUM_SONGS > 1) ? $clog2(NUM_SONGS) : 1;
  localparam int SPD_W  = $clog2(SPEED_LVLS);
  localparam int OFF_W  = $clog2(SONG_BYTES);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);
  localparam logic [SPD_W-1:0]  MAX_SPD   = SPD_W'(SPEED_LVLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_INIT,
    ST_PAUSE,
    ST_PLAY
  } state_t;

  state_t            state_q, state_d;
  logic [SONG_W-1:0] song_q, song_d, song_inc, song_dec;
  logic [ADDR_W-1:0] off_q, off_d;
  logic [SPD_W-1:0]  spd_q, spd_d, mult;
  logic              phase_q, phase_d;
  logic              rd_q, rd_d;
  logic              end_q, end_d;
  logic              rw_q, pause_q;
  logic [ADDR_W:0]   step, sum;

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    song_d  = song_q;
    off_d   = off_q;
    spd_d   = spd_q;
    phase_d = phase_q;
    rd_d    = 1'b0;
    end_d   = 1'b0;

    // Level 0 is half speed but still moves one sample per accepted request.
    mult     = (spd_q == '0) ? SPD_W'(1) : spd_q;
    step     = (ADDR_W+1)'(mult) * (ADDR_W+1)'(SAMPLE_BYTES);
    sum      = {1'b0, off_q} + step;
    song_inc = (song_q == LAST_SONG) ? '0 : song_q + 1'b1;
    song_dec = (song_q == '0) ? LAST_SONG : song_q - 1'b1;

    case (state_q)
      ST_IDLE: state_d = ST_INIT;
      ST_INIT: begin
        if (bus.init_finish) state_d = ST_PAUSE;
      end
      default: begin
        // Navigation beats play/pause, and both beat a coincident sample request.
        if (bus.cmd_restart) begin
          off_d   = '0;
          phase_d = 1'b0;
          rd_d    = (state_q == ST_PLAY);
        end else if (bus.cmd_next) begin
          song_d  = song_inc;
          off_d   = '0;
          phase_d = 1'b0;
          rd_d    = (state_q == ST_PLAY);
        end else if (bus.cmd_prev) begin
          song_d  = song_dec;
          off_d   = '0;
          phase_d = 1'b0;
          rd_d    = (state_q == ST_PLAY);
        end else if (bus.cmd_play_pause) begin
          state_d = (state_q == ST_PLAY) ? ST_PAUSE : ST_PLAY;
        end else if (state_q == ST_PLAY && bus.sample_req) begin
          if (spd_q == '0 && !phase_q) begin
            // First request of a half-speed pair only arms the phase.
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (sum < (ADDR_W+1)'(SONG_BYTES)) begin
              off_d = sum[ADDR_W-1:0];
              rd_d  = 1'b1;
            end else begin
              end_d  = 1'b1;
              song_d = song_inc;
              off_d  = '0;
              if (bus.loop_mode) rd_d = 1'b1;
              else               state_d = ST_PAUSE;
            end
          end
        end

        // Speed keys act independently; an actual level change restarts the half-speed pairing.
        if (bus.cmd_fast && !bus.cmd_slow && spd_q != MAX_SPD) begin
          spd_d   = spd_q + 1'b1;
          phase_d = 1'b0;
        end else if (bus.cmd_slow && !bus.cmd_fast && spd_q != '0) begin
          spd_d   = spd_q - 1'b1;
          phase_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge CLOCK or posedge Reset) begin
    if (Reset) begin
      song_q  <= '0;
      off_q   <= '0;
      spd_q   <= SPD_W'(1);
      phase_q <= 1'b0;
      rd_q    <= 1'b0;
      end_q   <= 1'b0;
      rw_q    <= 1'b0;
      pause_q <= 1'b0;
    end else begin
      song_q  <= song_d;
      off_q   <= off_d;
      spd_q   <= spd_d;
      phase_q <= phase_d;
      rd_q    <= rd_d;
      end_q   <= end_d;
      // Decoded from the next state so RW/PAUSE line up with state_q.
      rw_q    <= (state_d == ST_PLAY);
      pause_q <= (state_d == ST_PAUSE);
    end
  end

  // SONG_BYTES is a power of two and offset stays below it, so OR forms the sum.
  assign bus.mem_addr  = (ADDR_W'(song_q) << OFF_W) | off_q;
  assign bus.mem_rd    = rd_q;
  assign bus.song_idx  = song_q;
  assign bus.speed_lvl = spd_q;
  assign bus.RW        = rw_q;
  assign bus.PAUSE     = pause_q;
  assign bus.song_end  = end_q;
endmodule

// File: doc/player_ctrl_multi.md
Name: player_ctrl_multi

Overview:
Parametrised successor of the two-song play/pause control unit. It owns the player state machine (idle/init/pause/play) and a playlist of NUM_SONGS fixed-size flash regions. It generates the flash sample address stream with variable playback speed, restart, next/prev navigation and loop/stop-at-end mode. It sits between the board keys / remote decoder, the audio_interface (init_finish, data_over) and memreader (address, read strobe).

Parameters:
NUM_SONGS, 4, number of songs; song i occupies bytes [i*SONG_BYTES, (i+1)*SONG_BYTES)
ADDR_W, 23, flash byte-address width
SONG_BYTES, 2097152, bytes per song region (power of two, NUM_SONGS*SONG_BYTES <= 2**ADDR_W)
SAMPLE_BYTES, 2, bytes per 16-bit sample
SPEED_LVLS, 4, number of speed levels (>=2)

Ports:
CLOCK  in  1  system clock
Reset  in  1  asynchronous active-high reset (board key or remote reset, ORed upstream)
init_finish  in  1  codec init complete (level)
sample_req  in  1  one-cycle pulse per audio sample (data_over)
cmd_play_pause  in  1  one-cycle pulse, toggle play/pause
cmd_restart  in  1  one-cycle pulse, seek to start of current song
cmd_next  in  1  one-cycle pulse, next song
cmd_prev  in  1  one-cycle pulse, previous song
cmd_fast  in  1  one-cycle pulse, speed level +1
cmd_slow  in  1  one-cycle pulse, speed level -1
loop_mode  in  1  1: auto-continue at song end; 0: pause at song end
mem_addr  out  ADDR_W  current sample byte address
mem_rd  out  1  one-cycle read strobe to memreader
song_idx  out  clog2(NUM_SONGS)  current song (drives cover-art select)
speed_lvl  out  clog2(SPEED_LVLS)  current speed level
RW  out  1  high in PLAY
PAUSE  out  1  high in PAUSE
song_end  out  1  one-cycle pulse when a song region is exhausted

Behaviour:
- States: IDLE -> INIT (unconditional, 1 cycle) -> PAUSE when init_finish=1. PAUSE <-> PLAY on cmd_play_pause. RW/PAUSE are registered decodes of the state.
- Reset (async): state IDLE, song_idx 0, offset 0, mem_addr 0, speed_lvl 1, mem_rd 0, song_end 0, half-speed phase 0, RW 0, PAUSE 0.
- In IDLE/INIT, all cmd_* and sample_req are ignored.
- mem_addr = song_idx*SONG_BYTES + offset. offset is always a multiple of SAMPLE_BYTES.
- Command priority within one cycle: restart > next > prev > play_pause. fast/slow are independent of the others; fast and slow together = no change.
- restart: offset <= 0; state is unchanged.
- next: song_idx <= (song_idx+1) mod NUM_SONGS, offset <= 0; state is unchanged.
- prev: song_idx <= (song_idx-1) mod NUM_SONGS, offset <= 0; state is unchanged.
- A navigation command in PLAY issues mem_rd on the next cycle with the new address. A navigation command in PAUSE issues no mem_rd.
- Speed: level saturates at 0 and SPEED_LVLS-1. Level 0 = half speed: advance on every second sample_req, using the phase bit; the phase clears on any speed change or navigation. Level k>=1 = advance k samples per sample_req.
- Advance (PLAY, sample_req, and the half-speed phase allows it): step = k*SAMPLE_BYTES (1*SAMPLE_BYTES at level 0).
  - If offset+step < SONG_BYTES: offset <= offset+step.
  - Else: song_end pulses, song_idx increments with wrap, offset <= 0. If loop_mode=0, state -> PAUSE.
- mem_rd pulses the cycle after each offset update in PLAY, with mem_addr already updated, so latency from sample_req is 1 cycle. No mem_rd on a sample_req that does not advance.
- sample_req coinciding with any navigation command: the command wins and the sample advance is dropped.
- sample_req coinciding with cmd_play_pause from PLAY: go to PAUSE with no advance.
- sample_req coinciding with cmd_play_pause from PAUSE: go to PLAY; advancing starts on the next sample_req.
- Reset mid-play: immediate return to reset values; the sequence re-runs IDLE -> INIT.

Test Plan:
- Reset, init_finish=1 at cycle 5 -> IDLE, INIT, PAUSE; RW=0, PAUSE=1, mem_addr=0, speed_lvl=1.
- play_pause, then 3 sample_req at level 1 -> mem_addr 2, 4, 6 with one mem_rd each, one cycle after each request; play_pause again -> PAUSE, and further sample_req produce no mem_rd.
- Level 0 with 4 sample_req -> offsets 2, 4 (every second request); fast x5 from level 1 -> saturates at 3, stride 6 bytes.
- song_idx=3 (NUM_SONGS=4), offset = SONG_BYTES-2, sample_req: loop_mode=1 -> song_end pulse, song_idx=0, mem_addr=0, still PLAY; loop_mode=0 -> same, but state PAUSE.
- prev at song 0 -> song_idx 3, mem_addr 3*SONG_BYTES. Restart+next in the same cycle -> restart only. Next+sample_req in the same cycle -> offset 0, no advance.
- Reset asserted asynchronously mid-PLAY between clock edges -> outputs go to reset values without waiting for a CLOCK edge.
